// File: rtl/alu_pkg.sv
// Shared ALU datapath types: the NZCV flag bundle and the default operand width.
package alu_pkg;

  localparam int unsigned DEFAULT_WIDTH = 64;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/add_segment.sv
// Combinational ripple of SEG full adders; also exposes the carry into the segment MSB.
module add_segment #(
  parameter int unsigned SEG = 16
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           c_msb_in
);

  logic [SEG:0] w_c;

  always_comb begin
    w_c    = '0;
    sum    = '0;
    w_c[0] = cin;
    for (int unsigned i = 0; i < SEG; i++) begin
      sum[i]   = a[i] ^ b[i] ^ w_c[i];
      w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout     = w_c[SEG];
  assign c_msb_in = w_c[SEG-1];

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined add/sub: one SEG-bit carry segment resolved per stage, valid/ready on both
// sides, NZCV flags registered alongside the final-stage result.
module pipelined_add_sub
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int unsigned SEG = WIDTH / STAGES;

  if ((WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_add_sub: WIDTH (%0d) must be a multiple of STAGES (%0d)", WIDTH, STAGES);
  end

  logic [STAGES-1:0] r_valid;
  logic [STAGES-1:0] w_load;
  logic [STAGES-1:0] w_srcv;
  logic              w_down_free;
  flags_t            r_flags;

  // Walk from the output back to stage 0: a stage may load if it is empty or the
  // stage after it is taking its contents this cycle.
  always_comb begin
    w_load      = '0;
    w_down_free = out_ready;
    for (int unsigned i = 0; i < STAGES; i++) begin
      w_load[STAGES-1-i] = !r_valid[STAGES-1-i] || w_down_free;
      w_down_free        = w_load[STAGES-1-i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
    end else begin
      r_valid <= (r_valid & ~w_load) | (w_srcv & w_load);
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int unsigned PLO  = k * SEG;
    localparam int unsigned PUW  = WIDTH - PLO;
    localparam int unsigned LO   = PLO + SEG;
    localparam bit          LAST = (k == STAGES - 1);
    // Non-final layout: {upper b, upper a, carry, resolved low bits}.
    localparam int unsigned DW   = LAST ? WIDTH : 2 * WIDTH - LO + 1;

    logic [PUW-1:0] w_ua;
    logic [PUW-1:0] w_ub;
    logic           w_cin;
    logic [LO-1:0]  w_lo;
    logic [SEG-1:0] w_sum;
    logic           w_cout;
    logic [DW-1:0]  r_d;

    if (k == 0) begin : g_src
      assign w_ua      = a;
      assign w_ub      = sub ? ~b : b;
      assign w_cin     = sub;
      assign w_srcv[k] = in_valid;
      assign w_lo      = w_sum;
    end else begin : g_src
      assign w_ua      = g_st[k-1].r_d[PLO+1 +: PUW];
      assign w_ub      = g_st[k-1].r_d[PLO+1+PUW +: PUW];
      assign w_cin     = g_st[k-1].r_d[PLO];
      assign w_srcv[k] = r_valid[k-1];
      assign w_lo      = {w_sum, g_st[k-1].r_d[PLO-1:0]};
    end

    if (LAST) begin : g_tail
      logic w_cmsb;

      add_segment #(.SEG(SEG)) u_seg (
        .a        (w_ua[SEG-1:0]),
        .b        (w_ub[SEG-1:0]),
        .cin      (w_cin),
        .sum      (w_sum),
        .cout     (w_cout),
        .c_msb_in (w_cmsb)
      );

      always_ff @(posedge clk) begin
        if (reset) begin
          r_d     <= '0;
          r_flags <= '0;
        end else if (w_load[k] && w_srcv[k]) begin
          r_d     <= w_lo;
          r_flags <= '{n: w_lo[WIDTH-1], z: (w_lo == '0), c: w_cout, v: w_cout ^ w_cmsb};
        end
      end
    end else begin : g_body
      logic w_unused_cmsb;

      add_segment #(.SEG(SEG)) u_seg (
        .a        (w_ua[SEG-1:0]),
        .b        (w_ub[SEG-1:0]),
        .cin      (w_cin),
        .sum      (w_sum),
        .cout     (w_cout),
        .c_msb_in (w_unused_cmsb)
      );

      always_ff @(posedge clk) begin
        if (reset) begin
          r_d <= '0;
        end else if (w_load[k] && w_srcv[k]) begin
          r_d <= {w_ub[PUW-1:SEG], w_ua[PUW-1:SEG], w_cout, w_lo};
        end
      end
    end
  end

  assign in_ready  = w_load[0];
  assign out_valid = r_valid[STAGES-1];
  assign result    = g_st[STAGES-1].r_d;
  assign flag_n    = r_flags.n;
  assign flag_z    = r_flags.z;
  assign flag_c    = r_flags.c;
  assign flag_v    = r_flags.v;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed bench: three configurations (64/4, 32/1, 32/8) share stimulus; an output
// monitor logs every emitted result with its cycle stamp for the test tasks to inspect.
module tb_pipelined_add_sub;

  typedef struct {
    int          d;
    logic [63:0] r;
    logic [3:0]  f;
    int          cyc;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sub = 1'b0;
  logic        out_ready = 1'b1;
  logic        iv0 = 1'b0, iv1 = 1'b0, iv2 = 1'b0;
  logic [63:0] a64 = '0, b64 = '0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        ir0, ir1, ir2, ov0, ov1, ov2;
  logic [63:0] res0;
  logic [31:0] res1, res2;
  logic [3:0]  fl0, fl1, fl2;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t0 = 0;
  rec_t recs[$];

  pipelined_add_sub #(.WIDTH(64), .STAGES(4)) u_dut0 (
    .clk(clk), .reset(reset), .in_valid(iv0), .in_ready(ir0), .a(a64), .b(b64), .sub(sub),
    .out_valid(ov0), .out_ready(out_ready), .result(res0),
    .flag_n(fl0[3]), .flag_z(fl0[2]), .flag_c(fl0[1]), .flag_v(fl0[0])
  );

  pipelined_add_sub #(.WIDTH(32), .STAGES(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1), .a(a32), .b(b32), .sub(sub),
    .out_valid(ov1), .out_ready(out_ready), .result(res1),
    .flag_n(fl1[3]), .flag_z(fl1[2]), .flag_c(fl1[1]), .flag_v(fl1[0])
  );

  pipelined_add_sub #(.WIDTH(32), .STAGES(8)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(iv2), .in_ready(ir2), .a(a32), .b(b32), .sub(sub),
    .out_valid(ov2), .out_ready(out_ready), .result(res2),
    .flag_n(fl2[3]), .flag_z(fl2[2]), .flag_c(fl2[1]), .flag_v(fl2[0])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    rec_t m;
    if (ov0 && out_ready) begin
      m.d = 0; m.r = res0; m.f = fl0; m.cyc = cyc; recs.push_back(m);
    end
    if (ov1 && out_ready) begin
      m.d = 1; m.r = {32'd0, res1}; m.f = fl1; m.cyc = cyc; recs.push_back(m);
    end
    if (ov2 && out_ready) begin
      m.d = 2; m.r = {32'd0, res2}; m.f = fl2; m.cyc = cyc; recs.push_back(m);
    end
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 4 : (d == 1) ? 1 : 8;
  endfunction

  function automatic int count_recs(input int d);
    int n = 0;
    for (int i = 0; i < recs.size(); i++) if (recs[i].d == d) n++;
    return n;
  endfunction

  function automatic int find_rec(input int d, input int k);
    int seen = 0;
    for (int i = 0; i < recs.size(); i++) begin
      if (recs[i].d == d) begin
        if (seen == k) return i;
        seen++;
      end
    end
    return -1;
  endfunction

  // Reference: {result, n, z, c, v}; subtract carry is "no borrow" (a >= b unsigned).
  function automatic logic [67:0] model(input logic [63:0] x, input logic [63:0] y, input logic s);
    logic [64:0] t;
    logic [63:0] r;
    logic        c, v;
    if (s) begin
      r = x - y;
      c = (x >= y);
      v = (x[63] != y[63]) && (r[63] != x[63]);
    end else begin
      t = {1'b0, x} + {1'b0, y};
      r = t[63:0];
      c = t[64];
      v = (x[63] == y[63]) && (r[63] != x[63]);
    end
    return {r, r[63], (r == 64'd0), c, v};
  endfunction

  task automatic drive_dir(input logic [63:0] xa0, input logic [63:0] xb0,
                           input logic [31:0] ya0, input logic [31:0] yb0, input logic s0,
                           input logic two,
                           input logic [63:0] xa1, input logic [63:0] xb1,
                           input logic [31:0] ya1, input logic [31:0] yb1, input logic s1);
    @(posedge clk); #1;
    recs.delete();
    t0 = cyc;
    {iv0, iv1, iv2} = 3'b111;
    a64 = xa0; b64 = xb0; a32 = ya0; b32 = yb0; sub = s0;
    if (two) begin
      @(posedge clk); #1;
      a64 = xa1; b64 = xb1; a32 = ya1; b32 = yb1; sub = s1;
    end
    @(posedge clk); #1;
    {iv0, iv1, iv2} = 3'b000;
    repeat (12) @(posedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({ov0, ov1, ov2} !== 3'b000) begin
      errors++; $display("FAIL reset_out_valid: got %b want 000", {ov0, ov1, ov2});
    end
    checks++;
    if (res0 !== 64'd0 || res1 !== 32'd0 || res2 !== 32'd0) begin
      errors++; $display("FAIL reset_result: got %h %h %h want 0", res0, res1, res2);
    end
    checks++;
    if ({fl0, fl1, fl2} !== 12'd0) begin
      errors++; $display("FAIL reset_flags: got %b %b %b want 0000", fl0, fl1, fl2);
    end
    checks++;
    if ({ir0, ir1, ir2} !== 3'b111) begin
      errors++; $display("FAIL reset_in_ready: got %b want 111", {ir0, ir1, ir2});
    end
  endtask

  task automatic test_add_overflow();
    logic [63:0] er [3];
    int idx;
    er = '{64'h8000_0000_0000_0000, 64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000};
    drive_dir(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 32'h7FFF_FFFF, 32'd1, 1'b0,
              1'b0, '0, '0, '0, '0, 1'b0);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (count_recs(d) != 1) begin
        errors++; $display("FAIL add_ovf_count dut%0d: got %0d want 1", d, count_recs(d));
      end
      idx = find_rec(d, 0);
      checks++;
      if (idx < 0) begin
        errors++; $display("FAIL add_ovf dut%0d: no result, want %h", d, er[d]);
      end else if (recs[idx].r !== er[d] || recs[idx].f !== 4'b1001 || recs[idx].cyc - t0 != lat_of(d)) begin
        errors++;
        $display("FAIL add_ovf dut%0d: got res=%h nzcv=%b lat=%0d want res=%h nzcv=1001 lat=%0d",
                 d, recs[idx].r, recs[idx].f, recs[idx].cyc - t0, er[d], lat_of(d));
      end
    end
  endtask

  task automatic test_sub();
    logic [63:0] er [3][2];
    logic [3:0]  ef [2];
    int idx;
    er = '{'{64'd0, 64'hFFFF_FFFF_FFFF_FFFF}, '{64'd0, 64'hFFFF_FFFF}, '{64'd0, 64'hFFFF_FFFF}};
    ef = '{4'b0110, 4'b1000};
    drive_dir(64'd5, 64'd5, 32'd5, 32'd5, 1'b1,
              1'b1, 64'd0, 64'd1, 32'd0, 32'd1, 1'b1);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (count_recs(d) != 2) begin
        errors++; $display("FAIL sub_count dut%0d: got %0d want 2", d, count_recs(d));
      end
      for (int k = 0; k < 2; k++) begin
        idx = find_rec(d, k);
        checks++;
        if (idx < 0) begin
          errors++; $display("FAIL sub dut%0d op%0d: no result, want %h", d, k, er[d][k]);
        end else if (recs[idx].r !== er[d][k] || recs[idx].f !== ef[k] || recs[idx].cyc - t0 != lat_of(d) + k) begin
          errors++;
          $display("FAIL sub dut%0d op%0d: got res=%h nzcv=%b lat=%0d want res=%h nzcv=%b lat=%0d",
                   d, k, recs[idx].r, recs[idx].f, recs[idx].cyc - t0, er[d][k], ef[k], lat_of(d) + k);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] er [2];
    logic [3:0]  ef [2];
    int idx;
    er = '{64'd0, 64'd2};
    ef = '{4'b0110, 4'b0000};
    drive_dir(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 32'hFFFF_FFFF, 32'd1, 1'b0,
              1'b1, 64'd1, 64'd1, 32'd1, 32'd1, 1'b0);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (count_recs(d) != 2) begin
        errors++; $display("FAIL b2b_count dut%0d: got %0d want 2", d, count_recs(d));
      end
      for (int k = 0; k < 2; k++) begin
        idx = find_rec(d, k);
        checks++;
        if (idx < 0) begin
          errors++; $display("FAIL b2b dut%0d op%0d: no result, want %h", d, k, er[k]);
        end else if (recs[idx].r !== er[k] || recs[idx].f !== ef[k] || recs[idx].cyc - t0 != lat_of(d) + k) begin
          errors++;
          $display("FAIL b2b dut%0d op%0d: got res=%h nzcv=%b lat=%0d want res=%h nzcv=%b lat=%0d",
                   d, k, recs[idx].r, recs[idx].f, recs[idx].cyc - t0, er[k], ef[k], lat_of(d) + k);
        end
      end
    end
  endtask

  task automatic test_stream();
    logic [63:0] sa [10];
    logic [63:0] sb [10];
    logic        ss [10];
    logic [67:0] exp_v;
    logic [63:0] hr;
    logic [3:0]  hf;
    logic        held = 1'b0;
    logic        saw_block = 1'b0;
    int          sent = 0;
    int          k = 0;
    int          idx;
    for (int j = 0; j < 10; j++) begin
      sa[j] = {$urandom, $urandom};
      sb[j] = {$urandom, $urandom};
      ss[j] = 1'($urandom_range(0, 1));
    end
    sa[3] = 64'h8000_0000_0000_0000; sb[3] = 64'd1; ss[3] = 1'b1;
    @(posedge clk); #1;
    recs.delete();
    while (count_recs(0) < 10 && k < 80) begin
      @(posedge clk); #1;
      out_ready = !(k >= 6 && k <= 9);
      iv0 = (sent < 10);
      if (sent < 10) begin
        a64 = sa[sent]; b64 = sb[sent]; sub = ss[sent];
      end
      @(negedge clk);
      if (held) begin
        checks++;
        if (ov0 !== 1'b1 || res0 !== hr || fl0 !== hf) begin
          errors++;
          $display("FAIL stream_hold k=%0d: got v=%b res=%h nzcv=%b want v=1 res=%h nzcv=%b",
                   k, ov0, res0, fl0, hr, hf);
        end
      end
      held = ov0 && !out_ready;
      hr   = res0;
      hf   = fl0;
      if (iv0 && !ir0) saw_block = 1'b1;
      if (iv0 && ir0) sent++;
      k++;
    end
    @(posedge clk); #1;
    iv0 = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    checks++;
    if (!saw_block) begin
      errors++; $display("FAIL stream_in_ready: got never-low want low while full and stalled");
    end
    checks++;
    if (sent != 10) begin
      errors++; $display("FAIL stream_sent: got %0d want 10", sent);
    end
    checks++;
    if (count_recs(0) != 10) begin
      errors++; $display("FAIL stream_count: got %0d want 10", count_recs(0));
    end
    for (int j = 0; j < 10; j++) begin
      exp_v = model(sa[j], sb[j], ss[j]);
      idx = find_rec(0, j);
      checks++;
      if (idx < 0) begin
        errors++; $display("FAIL stream_op%0d: no result, want %h", j, exp_v[67:4]);
      end else if (recs[idx].r !== exp_v[67:4] || recs[idx].f !== exp_v[3:0]) begin
        errors++;
        $display("FAIL stream_op%0d: got res=%h nzcv=%b want res=%h nzcv=%b",
                 j, recs[idx].r, recs[idx].f, exp_v[67:4], exp_v[3:0]);
      end
    end
  endtask

  task automatic test_reset_midflight();
    @(posedge clk); #1;
    recs.delete();
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      iv0 = 1'b1; a64 = 64'(j + 1); b64 = 64'd7; sub = 1'b0;
      @(posedge clk); #1;
    end
    iv0 = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    checks++;
    if (count_recs(0) != 0) begin
      errors++; $display("FAIL midreset_emits: got %0d want 0", count_recs(0));
    end
    checks++;
    if (ov0 !== 1'b0 || res0 !== 64'd0 || fl0 !== 4'd0) begin
      errors++; $display("FAIL midreset_outputs: got v=%b res=%h nzcv=%b want v=0 res=0 nzcv=0000", ov0, res0, fl0);
    end
    checks++;
    if (ir0 !== 1'b1) begin
      errors++; $display("FAIL midreset_in_ready: got %b want 1", ir0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add_overflow();
    test_sub();
    test_back_to_back();
    test_stream();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
